serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial adder sequencer: one shared 1-bit full-adder cell adds two WIDTH-bit operands LSB-first,
//  one bit per clock, with carry held in a flop between bits. Start/done handshake to the requester;
//  result held stable until the next operation. Minimum-area alternative to a WIDTH-bit ripple adder.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=2)
// PORTS
//  clk     in   1      single clock, rising edge
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      request; sampled only in IDLE
//  a       in   WIDTH  operand A, captured on accepted start
//  b       in   WIDTH  operand B, captured on accepted start
//  cin     in   1      carry-in, captured on accepted start
//  busy    out  1      high in RUN and DONE; start ignored while high
//  done    out  1      one-cycle pulse: sum/cout valid from this cycle
//  sum     out  WIDTH  registered result; holds until next completion
//  cout    out  1      registered carry-out of bit WIDTH-1
//  ovf     out  1      signed overflow (only with SERIAL_ADD_OVF_EN)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, count=0, carry=0, shift regs=0.
//  - FSM: IDLE --start--> RUN --count==WIDTH-1--> DONE --(always)--> IDLE.
//  - IDLE: on edge with start=1, load a/b into shift regs, carry<=cin, count<=0, go RUN.
//  - RUN: each edge: cell(a_sr[0], b_sr[0], carry) -> s,c; carry<=c; s shifted into result reg MSB;
//    a_sr/b_sr shift right; count++. Exactly WIDTH RUN cycles.
//  - On the last RUN edge: sum<=final result, cout<=c, done<=1, go DONE. done high for exactly DONE cycle.
//  - Latency: start accepted at edge k -> done high after edge k+WIDTH (WIDTH+1 cycles incl. accept).
//  - Throughput: next start accepted in first IDLE cycle; back-to-back period = WIDTH+2 cycles.
//  - start while busy (RUN or DONE): ignored, no queueing; operands/cin changes while busy: no effect.
//  - sum/cout change only on completion edge; never show partial results.
//  - Cell arithmetic: s=x^y^ci, co=(x&y)|(x&ci)|(y&ci) (full majority carry).
//  - Result equals {cout,sum} = a + b + cin modulo 2^(WIDTH+1); no saturation.
//  - Reset mid-RUN: operation aborted, outputs return to reset values, no done pulse.
// CONFIGURATION
//  - SERIAL_ADD_OVF_EN defined: ovf port present; ovf<=carry_into_MSB ^ carry_out_of_MSB, written
//    on the completion edge together with sum; reset 0.
//  - Not defined: ovf port and its logic absent; all other behaviour identical.
// STRUCTURE
//  - Package serial_add_pkg: state enum (IDLE, RUN, DONE), state encoding width constant.
//  - Sub-module fa_cell: combinational 1-bit full adder (x, y, ci -> s, co), single instance.
//  - Top holds FSM, count (clog2(WIDTH) bits), carry flop, operand and result shift registers.
// TESTING (WIDTH=8)
//  - a=0x0F,b=0x01,cin=0 start -> done exactly 8 edges after accept, sum=0x10, cout=0, busy 9 cycles.
//  - a=0xFF,b=0x01,cin=0 -> sum=0x00, cout=1; then a=0xFF,b=0xFF,cin=1 back-to-back -> sum=0xFF, cout=1.
//  - start pulsed and a/b changed during RUN -> ignored, result of first op unchanged, single done.
//  - rst_n low at 4th RUN cycle -> all outputs 0 immediately, no done; next start works normally.
//  - OVF_EN: a=0x7F,b=0x01 -> sum=0x80, ovf=1; a=0x80,b=0x80 -> sum=0x00, cout=1, ovf=1; 0x10+0x10 -> ovf=0.
//  - Random: 1000 ops, scoreboard {cout,sum} vs a+b+cin, check done pulse width 1 and latency fixed.

Source files
------------

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types for the bit-serial adder sequencer
package serial_add_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - combinational 1-bit full adder cell
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencer, LSB first, one bit per clock
// Optional signed-overflow output enabled by SERIAL_ADD_OVF_EN.
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic             carry;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             cell_s;
    logic             cell_c;
    logic             last_bit;

    fa_cell u_fa_cell (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .ci (carry),
        .s  (cell_s),
        .co (cell_c)
    );

    // Partial result keeps only WIDTH-1 bits; the final bit joins it on the completion edge.
    assign res_next = {cell_s, res_sr};
    assign last_bit = (count == CW'(WIDTH - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            carry  <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        count <= '0;
                    end
                end
                RUN: begin
                    carry  <= cell_c;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next[WIDTH-1:1];
                    count  <= count + CW'(1);
                    if (last_bit) begin
                        sum   <= res_next;
                        cout  <= cell_c;
                        count <= '0;
`ifdef SERIAL_ADD_OVF_EN
                        // carry still holds the carry into the MSB during the last bit
                        ovf   <= carry ^ cell_c;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl (WIDTH=8)
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // {ovf, cout, sum}
    logic [W+1:0] sb_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W+1:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                           input logic xc);
        logic [W:0] full;
        logic       v;
        full = {1'b0, xa} + {1'b0, xb} + {{W{1'b0}}, xc};
        v    = (xa[W-1] == xb[W-1]) && (full[W-1] != xa[W-1]);
        return {v, full};
    endfunction

    // Called at a negedge; start is seen by the next rising edge, returns at the following negedge.
    task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
        a     = xa;
        b     = xb;
        cin   = xc;
        start = 1'b1;
        sb_q.push_back(model(xa, xb, xc));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_n, output bit to);
        lat    = 0;
        busy_n = busy ? 1 : 0;
        to     = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
            if (done) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    function automatic logic [W+1:0] observed();
`ifdef SERIAL_ADD_OVF_EN
        return {ovf, cout, sum};
`else
        return {1'b0, cout, sum};
`endif
    endfunction

    function automatic logic [W+1:0] result_mask();
`ifdef SERIAL_ADD_OVF_EN
        return {1'b1, {(W+1){1'b1}}};
`else
        return {1'b0, {(W+1){1'b1}}};
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, cout, sum} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h, want all 0",
                     busy, done, cout, sum);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_release_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int lat, bn;
        bit to;
        logic [W+1:0] exp;
        issue(8'h0F, 8'h01, 1'b0);
        wait_done(lat, bn, to);
        exp = sb_q.pop_front();
        n_cmp++;
        if (to || lat != W) begin
            n_err++;
            $display("FAIL basic_latency: got %0d (timeout=%0b), want %0d", lat, to, W);
        end
        n_cmp++;
        if (bn != W + 1) begin
            n_err++;
            $display("FAIL basic_busy_cycles: got %0d, want %0d", bn, W + 1);
        end
        n_cmp++;
        if ((observed() & result_mask()) !== (exp & result_mask()) || exp[W:0] !== 9'h010) begin
            n_err++;
            $display("FAIL basic_result: got %h, want %h", observed() & result_mask(), 9'h010);
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL basic_done_width: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        bit to;
        logic [W+1:0] exp;
        issue(8'hFF, 8'h01, 1'b0);
        wait_done(lat, bn, to);
        exp = sb_q.pop_front();
        n_cmp++;
        if (to || {cout, sum} !== 9'h100 || {cout, sum} !== exp[W:0]) begin
            n_err++;
            $display("FAIL b2b_first: got %h (timeout=%0b), want %h", {cout, sum}, to, 9'h100);
        end
        @(negedge clk);
        issue(8'hFF, 8'hFF, 1'b1);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept_first_idle: got busy=%b, want 1", busy);
        end
        wait_done(lat, bn, to);
        exp = sb_q.pop_front();
        n_cmp++;
        if (to || lat != W || {cout, sum} !== 9'h1FF || {cout, sum} !== exp[W:0]) begin
            n_err++;
            $display("FAIL b2b_second: got %h lat=%0d, want %h lat=%0d", {cout, sum}, lat, 9'h1FF, W);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int lat, bn, extra;
        bit to;
        logic [W+1:0] exp;
        issue(8'h3C, 8'h55, 1'b1);
        repeat (2) @(negedge clk);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        cin   = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(lat, bn, to);
        exp = sb_q.pop_front();
        n_cmp++;
        if (to || lat != W - 5) begin
            n_err++;
            $display("FAIL ignore_latency: got %0d (timeout=%0b), want %0d", lat, to, W - 5);
        end
        n_cmp++;
        if ({cout, sum} !== 9'h092 || {cout, sum} !== exp[W:0]) begin
            n_err++;
            $display("FAIL ignore_result: got %h, want %h", {cout, sum}, 9'h092);
        end
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL ignore_no_second_op: got %0d active cycles, want 0", extra);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bn, extra;
        bit to;
        logic [W+1:0] exp;
        issue(8'h11, 8'h22, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, cout, sum} !== '0) begin
            n_err++;
            $display("FAIL midrun_reset: got busy=%b done=%b cout=%b sum=%h, want all 0",
                     busy, done, cout, sum);
        end
        void'(sb_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL midrun_no_done: got %0d done cycles, want 0", extra);
        end
        issue(8'h21, 8'h43, 1'b1);
        wait_done(lat, bn, to);
        exp = sb_q.pop_front();
        n_cmp++;
        if (to || lat != W || {cout, sum} !== 9'h065 || {cout, sum} !== exp[W:0]) begin
            n_err++;
            $display("FAIL midrun_recover: got %h lat=%0d, want %h lat=%0d", {cout, sum}, lat, 9'h065, W);
        end
        @(negedge clk);
    endtask

`ifdef SERIAL_ADD_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] ta[3] = '{8'h7F, 8'h80, 8'h10};
        logic [W-1:0] tb[3] = '{8'h01, 8'h80, 8'h10};
        logic [W+1:0] want[3] = '{10'h280, 10'h300, 10'h020};
        int lat, bn;
        bit to;
        logic [W+1:0] exp;
        for (int i = 0; i < 3; i++) begin
            issue(ta[i], tb[i], 1'b0);
            wait_done(lat, bn, to);
            exp = sb_q.pop_front();
            n_cmp++;
            if (to || {ovf, cout, sum} !== want[i] || exp !== want[i]) begin
                n_err++;
                $display("FAIL ovf_case%0d: got ovf=%b cout=%b sum=%h, want %h", i, ovf, cout, sum, want[i]);
            end
            @(negedge clk);
        end
    endtask
`endif

    task automatic test_random();
        int lat, bn;
        bit to;
        logic [W+1:0] exp;
        for (int i = 0; i < 1000; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
            wait_done(lat, bn, to);
            exp = sb_q.pop_front();
            n_cmp++;
            if (to || lat != W) begin
                n_err++;
                $display("FAIL rand_latency[%0d]: got %0d (timeout=%0b), want %0d", i, lat, to, W);
            end
            n_cmp++;
            if ((observed() & result_mask()) !== (exp & result_mask())) begin
                n_err++;
                $display("FAIL rand_result[%0d]: got %h, want %h", i,
                         observed() & result_mask(), exp & result_mask());
            end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0) begin
                n_err++;
                $display("FAIL rand_done_width[%0d]: got done=%b, want 0", i, done);
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_run();
`ifdef SERIAL_ADD_OVF_EN
        test_ovf();
`endif
        test_random();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
